// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 constants, FSM encoding and GF(2^8) round helpers
package aes_pkg;

  localparam int NR  = 10;
  localparam int BLK = 128;
  localparam int KW  = 1408;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiplication by 3 is folded in as xtime(x) ^ x.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [BLK-1:0] shift_rows(input logic [BLK-1:0] s);
    logic [BLK-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[BLK-1-8*(4*c+row) -: 8] = s[BLK-1-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  // Round key r occupies words w(4r+1)..w(4r+4), w1 at the top of the bus.
  function automatic logic [BLK-1:0] round_key(input logic [KW-1:0] rk, input logic [3:0] r);
    return rk[KW-1-BLK*int'(r) -: BLK];
  endfunction

endpackage

// File: rtl/aes128_round_engine_if.sv
// rtl/aes128_round_engine_if.sv - plaintext in / ciphertext out handshake bundle
interface aes128_round_engine_if;
  import aes_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [BLK-1:0] plaintext;
  logic           out_valid;
  logic           out_ready;
  logic [BLK-1:0] ciphertext;

  modport master (
    output in_valid, plaintext, out_ready,
    input  in_ready, out_valid, ciphertext
  );

  modport slave (
    input  in_valid, plaintext, out_ready,
    output in_ready, out_valid, ciphertext
  );

endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box lookup
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0x00 sits in the top byte; row n holds entries 16n..16n+15.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] idx;

  assign idx = {~a, 3'b000};
  assign y   = SBOX[idx +: 8];

endmodule

// File: rtl/aes128_round_engine.sv
// rtl/aes128_round_engine.sv - iterative AES-128 encryptor, one round per clock
module aes128_round_engine
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KW-1:0]         round_keys,
  aes128_round_engine_if.slave  io,
  output logic                  busy
);

  state_e         state;
  logic [3:0]     rnd;
  logic [BLK-1:0] st;
  logic [BLK-1:0] sb;
  logic [BLK-1:0] sr;
  logic [BLK-1:0] mc;
  logic [BLK-1:0] nxt;
  logic           in_ready_q;
  logic           out_valid_q;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (
      .a (st[BLK-1-8*i -: 8]),
      .y (sb[BLK-1-8*i -: 8])
    );
  end

  assign sr = shift_rows(sb);

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc[BLK-1-32*c -: 32] = mix_column(sr[BLK-1-32*c -: 32]);
  end

  // The last round drops MixColumns.
  assign nxt = ((rnd == 4'(NR)) ? sr : mc) ^ round_key(round_keys, rnd);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rnd         <= 4'd0;
      st          <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid && in_ready_q) begin
            st         <= io.plaintext ^ round_key(round_keys, 4'd0);
            rnd        <= 4'd1;
            state      <= ROUND;
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ROUND: begin
          st <= nxt;
          if (rnd == 4'(NR)) begin
            rnd         <= 4'd0;
            state       <= DONE;
            busy        <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          // st is left untouched here so the result holds through any stall.
          if (io.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          rnd         <= 4'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  assign io.in_ready   = in_ready_q;
  assign io.out_valid  = out_valid_q;
  assign io.ciphertext = st;

endmodule

// File: tb/tb_aes128_round_engine.sv
// tb/tb_aes128_round_engine.sv - directed known-answer bench for aes128_round_engine
module tb_aes128_round_engine;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic          clk = 1'b0;
  logic          rst;
  logic [1407:0] rk;
  logic          busy;

  aes128_round_engine_if io ();

  aes128_round_engine dut (
    .clk        (clk),
    .rst        (rst),
    .round_keys (rk),
    .io         (io),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] sbox [256];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box derived from the field inverse plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv, r1, r2, r3, r4;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      end
      r1 = {inv[6:0], inv[7]};
      r2 = {r1[6:0], r1[7]};
      r3 = {r2[6:0], r2[7]};
      r4 = {r3[6:0], r3[7]};
      sbox[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] bus;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) bus[1407-32*i -: 32] = w[i];
    return bus;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [1407:0] bus);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ bus[1407-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = s[4*((c+row)%4)+row];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ bus[1407-128*r-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] exp_ct);
    int lat;
    io.plaintext = pt;
    io.in_valid  = 1'b1;
    tick();
    io.in_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_in_ready_low"}, io.in_ready, 0);
    lat = 0;
    while (!io.out_valid && lat < 30) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 10);
    check({tag, "_ct"}, io.ciphertext, exp_ct);
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, io.out_valid, 0);
    check({tag, "_in_ready_back"}, io.in_ready, 1);
  endtask

  initial begin
    int           lat;
    int           n_acc;
    int           n_out;
    int           acc_cyc [4];
    logic         acc;
    logic         hs;
    logic         ov_seen;
    logic [127:0] b2b_pt [4];
    logic [127:0] b2b_ct [4];

    rst          = 1'b1;
    rk           = '0;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    io.plaintext = '0;
    build_sbox();

    tick();
    tick();
    check("rst_out_valid", io.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ciphertext", io.ciphertext, 0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", io.in_ready, 1);

    rk = expand_key(KEY_B);
    run_block("kat_b", PT_B, CT_B);

    rk = expand_key(KEY_C);
    run_block("kat_c1", PT_C, CT_C);

    io.plaintext = PT_C;
    io.in_valid  = 1'b1;
    tick();
    io.in_valid = 1'b0;
    lat = 0;
    while (!io.out_valid && lat < 30) begin
      tick();
      lat++;
    end
    check("bp_latency", lat, 10);
    for (int k = 0; k < 20; k++) begin
      io.in_valid  = k[0];
      io.plaintext = ~PT_C;
      tick();
      check("bp_ct_stable", io.ciphertext, CT_C);
      check("bp_in_ready_low", io.in_ready, 0);
      check("bp_out_valid_held", io.out_valid, 1);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    check("bp_release_in_ready", io.in_ready, 1);
    check("bp_release_out_valid", io.out_valid, 0);

    rk = expand_key(KEY_B);
    b2b_pt[0] = 128'h00112233445566778899aabbccddeeff;
    b2b_pt[1] = 128'hffffffffffffffffffffffffffffffff;
    b2b_pt[2] = 128'h0123456789abcdeffedcba9876543210;
    b2b_pt[3] = PT_B;
    for (int i = 0; i < 4; i++) b2b_ct[i] = model_encrypt(b2b_pt[i], rk);
    n_acc        = 0;
    n_out        = 0;
    io.plaintext = b2b_pt[0];
    io.in_valid  = 1'b1;
    io.out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && n_out < 4; cyc++) begin
      acc = io.in_valid && io.in_ready;
      hs  = io.out_valid && io.out_ready;
      if (hs) begin
        check("b2b_ct", io.ciphertext, b2b_ct[n_out]);
        n_out++;
      end
      tick();
      if (acc) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 4) io.plaintext = b2b_pt[n_acc];
        else io.in_valid = 1'b0;
      end
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    check("b2b_accepts", n_acc, 4);
    check("b2b_results", n_out, 4);
    for (int k = 1; k < 4; k++) check("b2b_interval", acc_cyc[k] - acc_cyc[k-1], 12);

    io.plaintext = PT_B;
    io.in_valid  = 1'b1;
    tick();
    io.in_valid = 1'b0;
    repeat (4) tick();
    check("abort_busy_mid", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", io.out_valid, 0);
    check("abort_in_ready", io.in_ready, 1);
    check("abort_busy", busy, 0);
    ov_seen = 1'b0;
    repeat (15) begin
      tick();
      if (io.out_valid) ov_seen = 1'b1;
    end
    check("abort_no_result", ov_seen, 0);
    run_block("abort_recover", PT_B, CT_B);

    rk = expand_key(128'h0);
    run_block("zero", 128'h0, CT_Z);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
